ahb_cmd_master: RTL and testbench
=================================

Name: ahb_cmd_master

Overview:
AHB-Lite bus master, the initiator counterpart to the slaves on our bus (ROM, RAM, GPIO, UART, SPI). It accepts single read/write commands on a valid/ready interface and issues them as pipelined single NONSEQ transfers. The address phase of the next command overlaps the data phase of the current one. Each transfer returns one response in command order. It is intended as a second bus master (debug/loader bridge, test engine) behind an arbiter, or for standalone bus-slave verification.

Parameters:
HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, privileged data)
ALIGN_CHECK, 1, 1 = reject misaligned commands without a bus transfer; 0 = issue as given

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising HCLK
cmd_write  in  1  1 = write, 0 = read
cmd_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal and always rejected
cmd_addr  in  32  byte address
cmd_wdata  in  32  write data, already lane-positioned by the caller
rsp_valid  out  1  one-cycle pulse per completed command, no backpressure
rsp_rdata  out  32  HRDATA captured for reads; 0 for writes and errors
rsp_err  out  1  slave ERROR response, or rejected command
busy  out  1  any command held in the address or data stage
HADDR  out  32  AHB address
HTRANS  out  2  IDLE (00) or NONSEQ (10) only
HWRITE  out  1  AHB write
HSIZE  out  3  {1'b0, cmd_size}
HPROT  out  4  HPROT_VAL
HWDATA  out  32  write data during the data phase
HRDATA  in  32  read data
HREADY  in  1  transfer completing, from the bus multiplexer
HRESP  in  1  1 = ERROR

Behaviour:
- Reset (HRESETn low, asynchronous): HTRANS = IDLE; HADDR, HWDATA, rsp_rdata = 0; HWRITE, rsp_valid, rsp_err, busy = 0; HSIZE = 3'b000; cmd_ready = 0 while reset is asserted. All in-flight commands are dropped and no response is produced for them.
- Two stages, both registered:
  - A (address phase): holds a_valid and the command fields.
  - D (data phase): holds d_valid, d_write, d_wdata and d_rej.
- Bus outputs:
  - HADDR, HWRITE and HSIZE come from stage A.
  - HTRANS = NONSEQ when a_valid & ~a_rej & ~cancel, otherwise IDLE.
  - HWDATA comes from stage D.
- cmd_ready = ~a_valid | (HREADY & ~cancel & ~err_pending). This is combinational on HREADY; all other outputs are registered.
- Advance (HREADY=1 and not an error cycle):
  - D <= A.
  - A <= the new command if accepted, else a_valid = 0.
- Latency: command accepted at edge 0. Address phase in cycle 1, data phase in cycle 2 (zero wait states). rsp_valid is high in cycle 3, one cycle after the HREADY=1 that ends the data phase. Each slave wait state adds exactly 1 cycle.
- Back-to-back commands with cmd_valid held high give one NONSEQ per cycle, with no IDLE between them.
- Wait states (HREADY=0, HRESP=0): A and D hold, and all bus outputs stay stable.
- ERROR response, two-cycle:
  - Cycle E1 (HRESP=1, HREADY=0): set cancel.
  - Cycle E2: HTRANS is forced to IDLE. The command in A is kept, not lost.
  - At HREADY=1 & HRESP=1: the D command completes with rsp_err=1 and rsp_rdata=0. D then becomes empty; it is not loaded from A.
  - cancel clears on the following cycle and the A command is re-issued as NONSEQ.
- Rejection: applies when ALIGN_CHECK=1 and the address is misaligned (half: addr[0]; word: addr[1:0] != 0), and always when cmd_size=3. The command sets a_rej, drives HTRANS=IDLE, and still flows A→D in order. Its response is rsp_valid with rsp_err=1 in its normal slot.
- A read response captures HRDATA on the completing edge. A write response has rsp_rdata = 0.
- busy = a_valid | d_valid | rsp-pending.

Test Plan:
- Reset, then a word write of 0xCAFEF00D to 0x20000010 with zero wait states -> NONSEQ with HADDR=0x20000010 and HSIZE=2 in cycle 1; HWDATA=0xCAFEF00D in cycle 2; rsp_valid=1 and rsp_err=0 in cycle 3.
- Four back-to-back word reads at 0x0,0x4,0x8,0xC, slave returns 0x11,0x22,0x33,0x44 -> four consecutive NONSEQ cycles and four consecutive rsp_valid pulses with rdata 0x11..0x44 in order.
- Read with 3 wait states (HREADY low 3 cycles) while the next command is pending -> HADDR and HTRANS stable throughout, cmd_ready=0, rsp 3 cycles later than the zero-wait case.
- Slave ERROR on the first of two reads -> HTRANS=IDLE in E2, first rsp has rsp_err=1 and rdata=0, the second read is re-issued and its rsp is correct with rsp_err=0.
- Halfword write to 0x20000001 with ALIGN_CHECK=1 -> no NONSEQ on the bus, rsp_valid with rsp_err=1 in order after the preceding command's response.
- HRESETn pulsed low mid-transfer with 2 commands in flight -> outputs return to reset values asynchronously, no rsp_valid afterwards, and a new command works normally.

Source files
------------

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master: valid/ready commands in, pipelined NONSEQ transfers out,
// one in-order response per command. Address stage A overlaps data stage D.
module ahb_cmd_master #(
    parameter logic [3:0] HPROT_VAL   = 4'b0011,
    parameter bit         ALIGN_CHECK = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    logic        r_a_valid, r_a_write, r_a_rej;
    logic [1:0]  r_a_size;
    logic [31:0] r_a_addr, r_a_wdata;
    logic        r_d_valid, r_d_write, r_d_rej;
    logic [31:0] r_d_wdata;
    logic        r_cancel;
    logic        r_rsp_valid, r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic w_err, w_adv, w_accept, w_d_done, w_rej_new;

    // Only a real transfer sitting in the data phase can be answered with ERROR.
    assign w_err     = HRESP & r_d_valid & ~r_d_rej;
    assign w_adv     = HREADY & ~w_err & ~r_cancel;
    assign w_d_done  = r_d_valid & HREADY & (w_err | ~r_cancel);
    assign cmd_ready = HRESETn & (~r_a_valid | (HREADY & ~r_cancel & ~w_err));
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_rej_new = (cmd_size == 2'd3) |
                       (ALIGN_CHECK & (((cmd_size == 2'd1) & cmd_addr[0]) |
                                       ((cmd_size == 2'd2) & (cmd_addr[1:0] != 2'b00))));

    // Address stage: refills whenever it moves on or is empty.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_a_valid <= 1'b0;
            r_a_write <= 1'b0;
            r_a_rej   <= 1'b0;
            r_a_size  <= 2'd0;
            r_a_addr  <= 32'd0;
            r_a_wdata <= 32'd0;
        end else if (w_adv | ~r_a_valid) begin
            r_a_valid <= w_accept;
            if (w_accept) begin
                r_a_write <= cmd_write;
                r_a_rej   <= w_rej_new;
                r_a_size  <= cmd_size;
                r_a_addr  <= cmd_addr;
                r_a_wdata <= cmd_wdata;
            end
        end
    end

    // Data stage: takes A on advance; emptied (not refilled) by an ERROR completion.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_d_valid <= 1'b0;
            r_d_write <= 1'b0;
            r_d_rej   <= 1'b0;
            r_d_wdata <= 32'd0;
        end else if (w_adv) begin
            r_d_valid <= r_a_valid;
            r_d_write <= r_a_write;
            r_d_rej   <= r_a_rej;
            if (r_a_valid)
                r_d_wdata <= r_a_wdata;
        end else if (w_d_done) begin
            r_d_valid <= 1'b0;
        end
    end

    // Cancel covers the second ERROR cycle so the pending address is withdrawn.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_cancel <= 1'b0;
        else if (w_err & ~HREADY)
            r_cancel <= 1'b1;
        else if (HREADY)
            r_cancel <= 1'b0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= w_d_done;
            if (w_d_done) begin
                r_rsp_err   <= r_d_rej | w_err;
                r_rsp_rdata <= (r_d_write | r_d_rej | w_err) ? 32'd0 : HRDATA;
            end
        end
    end

    assign HADDR     = r_a_addr;
    assign HWRITE    = r_a_write;
    assign HSIZE     = {1'b0, r_a_size};
    assign HTRANS    = (r_a_valid & ~r_a_rej & ~r_cancel) ? 2'b10 : 2'b00;
    assign HPROT     = HPROT_VAL;
    assign HWDATA    = r_d_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_a_valid | r_d_valid | r_rsp_valid;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: the bus slave side is driven cycle by cycle from tables
// of hand-derived values; every output check goes through chk().
module tb_ahb_cmd_master;

    logic        HCLK, HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_cmd_master #(.HPROT_VAL(4'b0011), .ALIGN_CHECK(1'b1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic v, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        cmd_valid = v; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = d;
    endtask

    task automatic bus(input logic rdy, input logic rsp, input logic [31:0] rd);
        HREADY = rdy; HRESP = rsp; HRDATA = rd;
    endtask

    // Enter the next cycle shortly after its rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        cmd(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        #2;
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("hprot", 32'(HPROT), 32'h3);
        #21 HRESETn = 1'b1;
        step(); step();

        // T1: single word write, zero wait
        cmd(1'b1, 1'b1, 2'd2, 32'h2000_0010, 32'hCAFE_F00D); #1;
        chk("t1_ready_c0", 32'(cmd_ready), 32'd1);
        step(); cmd(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); #1;
        chk("t1_htrans_c1", 32'(HTRANS), 32'h2);
        chk("t1_haddr_c1", HADDR, 32'h2000_0010);
        chk("t1_hsize_c1", 32'(HSIZE), 32'd2);
        chk("t1_hwrite_c1", 32'(HWRITE), 32'd1);
        chk("t1_busy_c1", 32'(busy), 32'd1);
        step(); #1;
        chk("t1_hwdata_c2", HWDATA, 32'hCAFE_F00D);
        chk("t1_htrans_c2", 32'(HTRANS), 32'd0);
        chk("t1_rspv_c2", 32'(rsp_valid), 32'd0);
        step(); #1;
        chk("t1_rspv_c3", 32'(rsp_valid), 32'd1);
        chk("t1_rsperr_c3", 32'(rsp_err), 32'd0);
        chk("t1_rdata_c3", rsp_rdata, 32'd0);
        step(); #1;
        chk("t1_rspv_c4", 32'(rsp_valid), 32'd0);
        chk("t1_busy_c4", 32'(busy), 32'd0);

        // T2: four back-to-back word reads, slave returns 0x11..0x44
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) step();
            cmd(k < 4, 1'b0, 2'd2, 32'(4 * k), 32'd0);
            bus(1'b1, 1'b0, (k >= 2 && k <= 5) ? 32'(8'h11 * (k - 1)) : 32'd0);
            #1;
            if (k < 4) chk($sformatf("t2_ready_c%0d", k), 32'(cmd_ready), 32'd1);
            if (k >= 1 && k <= 4) begin
                chk($sformatf("t2_htrans_c%0d", k), 32'(HTRANS), 32'h2);
                chk($sformatf("t2_haddr_c%0d", k), HADDR, 32'(4 * (k - 1)));
            end
            if (k == 5) chk("t2_htrans_c5", 32'(HTRANS), 32'd0);
            chk($sformatf("t2_rspv_c%0d", k), 32'(rsp_valid), (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
            if (k >= 3 && k <= 6)
                chk($sformatf("t2_rdata_c%0d", k), rsp_rdata, 32'(8'h11 * (k - 2)));
        end

        // T3: read with 3 wait states while the next commands are pending
        cmd(1'b1, 1'b0, 2'd2, 32'h100, 32'd0); bus(1'b1, 1'b0, 32'd0); #1;
        step(); cmd(1'b1, 1'b0, 2'd2, 32'h104, 32'd0); #1;
        chk("t3_haddr_c1", HADDR, 32'h100);
        for (int k = 2; k <= 5; k++) begin
            step();
            cmd(1'b1, 1'b0, 2'd2, 32'h108, 32'd0);
            bus(k == 5, 1'b0, (k == 5) ? 32'hAAAA_5555 : 32'hDEAD_BEEF);
            #1;
            chk($sformatf("t3_haddr_c%0d", k), HADDR, 32'h104);
            chk($sformatf("t3_htrans_c%0d", k), 32'(HTRANS), 32'h2);
            chk($sformatf("t3_ready_c%0d", k), 32'(cmd_ready), (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("t3_rspv_c%0d", k), 32'(rsp_valid), 32'd0);
        end
        step(); cmd(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); bus(1'b1, 1'b0, 32'h2); #1;
        chk("t3_rspv_c6", 32'(rsp_valid), 32'd1);
        chk("t3_rdata_c6", rsp_rdata, 32'hAAAA_5555);
        chk("t3_haddr_c6", HADDR, 32'h108);
        step(); bus(1'b1, 1'b0, 32'h3); #1;
        chk("t3_rdata_c7", rsp_rdata, 32'h2);
        step(); bus(1'b1, 1'b0, 32'd0); #1;
        chk("t3_rdata_c8", rsp_rdata, 32'h3);
        step(); #1;

        // T4: ERROR on the first of two reads
        cmd(1'b1, 1'b0, 2'd2, 32'h200, 32'd0); #1;
        step(); cmd(1'b1, 1'b0, 2'd2, 32'h204, 32'd0); #1;
        step(); cmd(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); bus(1'b0, 1'b1, 32'hBAD0_BAD0); #1;
        chk("t4_htrans_e1", 32'(HTRANS), 32'h2);
        chk("t4_ready_e1", 32'(cmd_ready), 32'd0);
        step(); bus(1'b1, 1'b1, 32'hBAD0_BAD0); #1;
        chk("t4_htrans_e2", 32'(HTRANS), 32'd0);
        chk("t4_haddr_e2", HADDR, 32'h204);
        chk("t4_rspv_e2", 32'(rsp_valid), 32'd0);
        step(); bus(1'b1, 1'b0, 32'd0); #1;
        chk("t4_rspv_c4", 32'(rsp_valid), 32'd1);
        chk("t4_rsperr_c4", 32'(rsp_err), 32'd1);
        chk("t4_rdata_c4", rsp_rdata, 32'd0);
        chk("t4_reissue_htrans", 32'(HTRANS), 32'h2);
        chk("t4_reissue_haddr", HADDR, 32'h204);
        step(); bus(1'b1, 1'b0, 32'h55); #1;
        chk("t4_rspv_c5", 32'(rsp_valid), 32'd0);
        step(); bus(1'b1, 1'b0, 32'd0); #1;
        chk("t4_rspv_c6", 32'(rsp_valid), 32'd1);
        chk("t4_rsperr_c6", 32'(rsp_err), 32'd0);
        chk("t4_rdata_c6", rsp_rdata, 32'h55);
        step(); #1;

        // T5: read then misaligned halfword write (rejected, in order)
        cmd(1'b1, 1'b0, 2'd2, 32'h300, 32'd0); #1;
        step(); cmd(1'b1, 1'b1, 2'd1, 32'h2000_0001, 32'h0000_BEEF); #1;
        chk("t5_htrans_c1", 32'(HTRANS), 32'h2);
        step(); cmd(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); bus(1'b1, 1'b0, 32'h77); #1;
        chk("t5_htrans_rej", 32'(HTRANS), 32'd0);
        step(); bus(1'b1, 1'b0, 32'd0); #1;
        chk("t5_rspv_c3", 32'(rsp_valid), 32'd1);
        chk("t5_rsperr_c3", 32'(rsp_err), 32'd0);
        chk("t5_rdata_c3", rsp_rdata, 32'h77);
        chk("t5_htrans_c3", 32'(HTRANS), 32'd0);
        step(); #1;
        chk("t5_rspv_c4", 32'(rsp_valid), 32'd1);
        chk("t5_rsperr_c4", 32'(rsp_err), 32'd1);
        chk("t5_rdata_c4", rsp_rdata, 32'd0);
        chk("t5_busy_c4", 32'(busy), 32'd1);
        step(); #1;
        chk("t5_rspv_c5", 32'(rsp_valid), 32'd0);
        chk("t5_busy_c5", 32'(busy), 32'd0);

        // T5b: size 3 is rejected even when aligned
        cmd(1'b1, 1'b1, 2'd3, 32'h0, 32'h1); #1;
        step(); cmd(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); #1;
        chk("t5b_htrans_c1", 32'(HTRANS), 32'd0);
        step(); step(); #1;
        chk("t5b_rspv_c3", 32'(rsp_valid), 32'd1);
        chk("t5b_rsperr_c3", 32'(rsp_err), 32'd1);
        step(); #1;

        // T6: asynchronous reset with two commands in flight
        cmd(1'b1, 1'b0, 2'd2, 32'h400, 32'd0); #1;
        step(); cmd(1'b1, 1'b0, 2'd2, 32'h404, 32'd0); #1;
        step(); cmd(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); bus(1'b1, 1'b0, 32'h99); #1;
        chk("t6_busy_pre", 32'(busy), 32'd1);
        HRESETn = 1'b0; #1;
        chk("t6_htrans_rst", 32'(HTRANS), 32'd0);
        chk("t6_haddr_rst", HADDR, 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_ready_rst", 32'(cmd_ready), 32'd0);
        chk("t6_rspv_rst", 32'(rsp_valid), 32'd0);
        @(posedge HCLK); #3 HRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk($sformatf("t6_no_rsp_%0d", k), 32'(rsp_valid), 32'd0);
        end
        cmd(1'b1, 1'b1, 2'd2, 32'h2000_0020, 32'h1234_5678); #1;
        chk("t6_ready_c0", 32'(cmd_ready), 32'd1);
        step(); cmd(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); #1;
        chk("t6_htrans_c1", 32'(HTRANS), 32'h2);
        chk("t6_haddr_c1", HADDR, 32'h2000_0020);
        step(); #1;
        chk("t6_hwdata_c2", HWDATA, 32'h1234_5678);
        step(); #1;
        chk("t6_rspv_c3", 32'(rsp_valid), 32'd1);
        chk("t6_rsperr_c3", 32'(rsp_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
